dmem_responder: RTL

- Data-memory responder at the MEM end of the EX/MEM pipeline interface.
- Consumes the MEM-stage request signals: read request, write request, address, store data.
- Models a fixed-latency data memory and holds the EX/MEM register with stall_m until each access completes.
- Returns registered load data for the MEM/WB register.

---
 rtl/dmem_responder_pkg.sv | 19 +
 rtl/dmem_responder_array.sv | 53 +++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the MEM-stage data-memory responder:
//   default widths, default access latency and the responder FSM state type.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

    localparam int PC_BITS          = 32;  // address / data word width
    localparam int DMEM_ADDR_BITS   = 10;  // word-address bits (1024 words)
    localparam int DMEM_WAIT_CYCLES = 2;   // stall cycles per access (1..15)
    localparam int DMEM_CNT_BITS    = 4;   // wide enough for WAIT_CYCLES-2 <= 13

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

endpackage : dmem_responder_pkg

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_responder_array
//   Single-port data array with synchronous write and a registered read port.
//   A read and a write on the same edge return the word as it was before the
//   write (read-before-write).
//
// Ports:
//   clk    in   clock
//   clr    in   synchronous clear of the read-data register only
//   we     in   write enable
//   re     in   read enable; rdata holds when low
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module dmem_responder_array
    import dmem_responder_pkg::*;
#(
    parameter int DATA_BITS = PC_BITS,
    parameter int ADDR_BITS = DMEM_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
    logic [DATA_BITS-1:0] rdata_q;

    // NOTE: the storage array has no reset so it maps onto RAM macros; only
    // the small read register below is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Non-blocking read of mem_q sees the pre-write word on a shared edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule : dmem_responder_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Fixed-latency data-memory responder at the MEM end of the EX/MEM register.
//   Each load/store request stalls the pipeline for exactly WAIT_CYCLES
//   cycles, completes on the last stall edge, then spends one DONE cycle with
//   stall_m low so EX/MEM and MEM/WB advance together.
//
// Optional feature (macro DMEM_MISALIGN_TRAP_EN):
//   Adds misaligned_m. A request from IDLE with alu_out_m[1:0] != 0 raises
//   misaligned_m for that cycle, does not stall, does not touch the array,
//   clears read_data_m and stays in IDLE.
//
// Ports:
//   clk           in   clock
//   clr           in   synchronous active-high reset
//   mem_to_reg_m  in   load request
//   mem_write_m   in   store request
//   alu_out_m     in   byte address (word index = [ADDR_BITS+1:2])
//   write_data_m  in   store data
//   read_data_m   out  registered load data
//   stall_m       out  hold EX/MEM register
//   misaligned_m  out  misaligned request trap (only with the macro)
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_BITS   = PC_BITS,
    parameter int ADDR_BITS   = DMEM_ADDR_BITS,
    parameter int WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 mem_to_reg_m,
    input  logic                 mem_write_m,
    input  logic [DATA_BITS-1:0] alu_out_m,
    input  logic [DATA_BITS-1:0] write_data_m,
    output logic [DATA_BITS-1:0] read_data_m,
    output logic                 stall_m
`ifdef DMEM_MISALIGN_TRAP_EN
    ,
    output logic                 misaligned_m
`endif
);

    dmem_state_t              state_q, state_d;
    logic [DMEM_CNT_BITS-1:0] cnt_q, cnt_d;

    logic                 req;
    logic                 trap;        // misaligned request seen in IDLE
    logic                 complete;    // access commits at this edge
    logic                 arr_we;
    logic                 arr_re;
    logic                 arr_clr;
    logic [ADDR_BITS-1:0] word_addr;
    logic                 addr_unused;

    assign req       = mem_to_reg_m | mem_write_m;
    assign word_addr = alu_out_m[ADDR_BITS+1:2];

    // Byte-offset and upper address bits alias by design.
    assign addr_unused = ^{alu_out_m[DATA_BITS-1:ADDR_BITS+2], alu_out_m[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap         = !clr && (state_q == IDLE) && req && (alu_out_m[1:0] != 2'b00);
    assign misaligned_m = trap;
`else
    assign trap = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_m  = 1'b0;
        complete = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req && !trap) begin
                    stall_m = 1'b1;
                    if (WAIT_CYCLES == 1) begin
                        complete = 1'b1;
                        state_d  = DONE;
                    end else begin
                        cnt_d   = DMEM_CNT_BITS'(WAIT_CYCLES - 2);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_m = 1'b1;
                if (!req) begin
                    // Pipeline flush removed the request: abort, no side effects.
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset overrides everything so an in-flight store never commits.
        if (clr) begin
            stall_m  = 1'b0;
            complete = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
        end
    end

    // A combined load+store is a store whose read port returns the old word.
    assign arr_we  = complete & mem_write_m;
    assign arr_re  = complete & mem_to_reg_m;
    assign arr_clr = clr | trap;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    dmem_responder_array #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .clr   (arr_clr),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (word_addr),
        .wdata (write_data_m),
        .rdata (read_data_m)
    );

endmodule : dmem_responder
